// File: rtl/stopwatch_counter.sv
// Stopwatch timebase and control FSM: 1/100 s count with start/stop, lap and clear keys.
// Define STOPWATCH_DEBOUNCE_EN to insert a DEB_CYCLES-long per-key debounce filter.
module stopwatch_counter #(
  parameter int unsigned TICK_DIV   = 10000,
  parameter logic [3:0]  SW_MODE    = 4'b0010,
  parameter int unsigned DEB_CYCLES = 20000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  enable,
  input  logic [11:0] keypad_in,
  output logic [23:0] stopwatch_clock,
  output logic        running,
  output logic        overflow
);

  localparam int unsigned PrescW = $clog2(TICK_DIV);
  localparam logic [PrescW-1:0] PrescLast = PrescW'(TICK_DIV - 1);

  if (TICK_DIV < 2 || DEB_CYCLES < 1) begin : g_bad_param
    $error("stopwatch_counter: TICK_DIV must be >= 2 and DEB_CYCLES >= 1");
  end

  typedef enum logic [1:0] {StIdle, StRun, StLap, StPause} state_e;

  state_e              state_q, state_d;
  logic [PrescW-1:0]   presc_q;
  logic [23:0]         count_q, lap_q, count_inc;
  logic                count_wrap;
  logic [2:0]          sync1_q, sync2_q, level_prev_q, pulse_q, key_level;
  logic                unused_keys;

  assign unused_keys = ^keypad_in[11:3];

  // Key path: 2-FF synchronizer, optional filter, registered rising-edge pulse.
  always_ff @(posedge clk) begin
    if (resetn) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      level_prev_q <= '0;
      pulse_q      <= '0;
    end else begin
      sync1_q      <= keypad_in[2:0];
      sync2_q      <= sync1_q;
      level_prev_q <= key_level;
      pulse_q      <= key_level & ~level_prev_q;
    end
  end

`ifdef STOPWATCH_DEBOUNCE_EN
  localparam int unsigned DebW = $clog2(DEB_CYCLES + 1);
  localparam logic [DebW-1:0] DebLast = DebW'(DEB_CYCLES - 1);

  logic [2:0]      filt_q;
  logic [DebW-1:0] deb_cnt_q [3];

  // Filtered level flips only after DEB_CYCLES consecutive differing samples.
  always_ff @(posedge clk) begin
    if (resetn) begin
      filt_q <= '0;
      for (int k = 0; k < 3; k++) deb_cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (sync2_q[k] == filt_q[k]) begin
          deb_cnt_q[k] <= '0;
        end else if (deb_cnt_q[k] == DebLast) begin
          filt_q[k]    <= sync2_q[k];
          deb_cnt_q[k] <= '0;
        end else begin
          deb_cnt_q[k] <= deb_cnt_q[k] + DebW'(1);
        end
      end
    end
  end

  assign key_level = filt_q;
`else
  assign key_level = sync2_q;
`endif

  logic mode_ok, do_clear, do_start, do_lap, counting, tick;

  assign mode_ok  = (enable == SW_MODE);
  assign do_clear = mode_ok & pulse_q[2];
  assign do_start = mode_ok & pulse_q[0] & ~pulse_q[2];
  assign do_lap   = mode_ok & pulse_q[1] & ~pulse_q[0] & ~pulse_q[2];
  assign counting = (state_q == StRun) || (state_q == StLap);
  assign tick     = counting && (presc_q == PrescLast);

  logic [7:0] cen_f, sec_f, min_f;
  assign {min_f, sec_f, cen_f} = count_q;

  always_comb begin
    count_inc  = count_q;
    count_wrap = 1'b0;
    if (cen_f != 8'd99) begin
      count_inc[7:0] = cen_f + 8'd1;
    end else begin
      count_inc[7:0] = '0;
      if (sec_f != 8'd59) begin
        count_inc[15:8] = sec_f + 8'd1;
      end else begin
        count_inc[15:8] = '0;
        if (min_f != 8'd99) begin
          count_inc[23:16] = min_f + 8'd1;
        end else begin
          count_inc[23:16] = '0;
          count_wrap       = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (do_start) state_d = StRun;
      StRun:   if (do_start) state_d = StPause; else if (do_lap) state_d = StLap;
      StLap:   if (do_start) state_d = StPause; else if (do_lap) state_d = StRun;
      StPause: if (do_clear) state_d = StIdle;  else if (do_start) state_d = StRun;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q         <= StIdle;
      presc_q         <= '0;
      count_q         <= '0;
      lap_q           <= '0;
      stopwatch_clock <= '0;
      running         <= 1'b0;
      overflow        <= 1'b0;
    end else begin
      state_q         <= state_d;
      running         <= (state_d == StRun) || (state_d == StLap);
      stopwatch_clock <= (state_q == StLap) ? lap_q : count_q;

      // A tick on the same edge as a stop is still counted.
      if (tick) begin
        presc_q <= '0;
        count_q <= count_inc;
        if (count_wrap) overflow <= 1'b1;
      end else if (counting) begin
        presc_q <= presc_q + PrescW'(1);
      end

      if (state_q == StIdle && state_d == StRun) presc_q <= '0;
      if (state_q == StRun && state_d == StLap) lap_q <= count_q;
      if (state_q == StPause && state_d == StIdle) begin
        count_q  <= '0;
        presc_q  <= '0;
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed self-checking bench for stopwatch_counter with TICK_DIV = 4.
module tb_stopwatch_counter;

  localparam int unsigned TickDiv   = 4;
  localparam logic [3:0]  SwMode    = 4'b0010;
  localparam int unsigned DebCycles = 8;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  enable;
  logic [11:0] keypad_in;
  logic [23:0] stopwatch_clock;
  logic        running;
  logic        overflow;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  stopwatch_counter #(
    .TICK_DIV  (TickDiv),
    .SW_MODE   (SwMode),
    .DEB_CYCLES(DebCycles)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .enable         (enable),
    .keypad_in      (keypad_in),
    .stopwatch_clock(stopwatch_clock),
    .running        (running),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %b, want %b", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Raw keys high for exactly one edge; n = index of that edge.
  task automatic press(input logic [2:0] keys, output int n);
    keypad_in = {9'b0, keys};
    @(posedge clk);
    #1;
    keypad_in = '0;
    n = cyc;
  endtask

  initial begin
    int n, s, e, l;
    resetn    = 1'b1;
    enable    = SwMode;
    keypad_in = 12'h007;
    repeat (3) @(posedge clk);
    #1;
    check("reset_clock", stopwatch_clock, 24'h000000);
    check_bit("reset_running", running, 1'b0);
    check_bit("reset_overflow", overflow, 1'b0);
    keypad_in = '0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;

`ifdef STOPWATCH_DEBOUNCE_EN
    for (int i = 0; i < 6; i++) begin
      keypad_in = 12'h001;
      repeat (3) @(posedge clk);
      #1;
      keypad_in = 12'h000;
      repeat (3) @(posedge clk);
      #1;
    end
    repeat (10) @(posedge clk);
    #1;
    check_bit("deb_bounce_ignored", running, 1'b0);
    keypad_in = 12'h001;
    @(posedge clk);
    #1;
    n = cyc;
    wait_cyc(n + 10);
    check_bit("deb_before_11", running, 1'b0);
    wait_cyc(n + 11);
    check_bit("deb_at_11", running, 1'b1);
    wait_cyc(n + 20);
    keypad_in = '0;
    repeat (20) @(posedge clk);
    #1;
    check_bit("deb_still_run", running, 1'b1);
`else
    // Reset and run: one second is 100 ticks of 4 cycles.
    press(3'b001, n);
    s = n + 3;
    wait_cyc(n + 2);
    check_bit("t1_not_yet", running, 1'b0);
    wait_cyc(s);
    check_bit("t1_running", running, 1'b1);
    wait_cyc(s + 400);
    check("t1_99_centi", stopwatch_clock, 24'h000063);
    wait_cyc(s + 401);
    check("t1_one_sec", stopwatch_clock, 24'h000100);

    // Rollover from 99:59.99 with the prescaler preloaded to 0.
    press(3'b001, n);
    wait_cyc(n + 3);
    check_bit("t2_paused", running, 1'b0);
    force dut.count_q = 24'h633B63;
    force dut.presc_q = '0;
    @(posedge clk);
    #1;
    release dut.count_q;
    release dut.presc_q;
    @(posedge clk);
    #1;
    check("t2_preload", stopwatch_clock, 24'h633B63);
    press(3'b001, n);
    e = n + 3;
    wait_cyc(e + 3);
    check_bit("t2_ovf_before", overflow, 1'b0);
    wait_cyc(e + 4);
    check("t2_last", stopwatch_clock, 24'h633B63);
    check_bit("t2_ovf_set", overflow, 1'b1);
    press(3'b001, n);
    check("t2_wrap", stopwatch_clock, 24'h000000);
    check_bit("t2_running", running, 1'b1);
    // That stop lands on the e+8 tick, which must still count.
    wait_cyc(e + 7);
    check_bit("t5_run_before_stop", running, 1'b1);
    wait_cyc(e + 8);
    check_bit("t5_coinc_pause", running, 1'b0);
    wait_cyc(e + 20);
    check("t5_tick_counted", stopwatch_clock, 24'h000001);
    check_bit("t2_ovf_sticky", overflow, 1'b1);
    press(3'b100, n);
    wait_cyc(n + 3);
    check_bit("t2_ovf_clear", overflow, 1'b0);
    wait_cyc(n + 4);
    check("t2_cleared", stopwatch_clock, 24'h000000);

    // Lap at 37 centiseconds, release after 40 more ticks.
    press(3'b001, n);
    s = n + 3;
    wait_cyc(s + 146);
    press(3'b010, n);
    l = n + 3;
    wait_cyc(l + 1);
    check("t3_lap_frozen", stopwatch_clock, 24'h000025);
    wait_cyc(l + 41);
    check("t3_lap_hold", stopwatch_clock, 24'h000025);
    check_bit("t3_lap_running", running, 1'b1);
    wait_cyc(l + 156);
    press(3'b010, n);
    wait_cyc(l + 161);
    check("t3_lap_live", stopwatch_clock, 24'h00004D);

    // Start and clear together in PAUSE: clear wins.
    press(3'b001, n);
    wait_cyc(n + 3);
    check_bit("t5_pause", running, 1'b0);
    press(3'b101, n);
    wait_cyc(n + 3);
    check_bit("t5_prio_state", running, 1'b0);
    wait_cyc(n + 4);
    check("t5_prio_cleared", stopwatch_clock, 24'h000000);
    wait_cyc(n + 20);
    check_bit("t5_prio_idle", running, 1'b0);

    // Mode gating.
    enable = 4'b1000;
    press(3'b001, n);
    wait_cyc(n + 10);
    check_bit("t4_gated_idle", running, 1'b0);
    enable = SwMode;
    press(3'b001, n);
    s = n + 3;
    wait_cyc(s);
    check_bit("t4_run", running, 1'b1);
    enable = 4'b1000;
    wait_cyc(s + 9);
    press(3'b001, n);
    wait_cyc(s + 20);
    check_bit("t4_gated_run", running, 1'b1);
    enable = SwMode;
    wait_cyc(s + 36);
    press(3'b001, n);
    wait_cyc(s + 41);
    check("t4_pause_count", stopwatch_clock, 24'h00000A);
    wait_cyc(s + 1041);
    check("t4_frozen", stopwatch_clock, 24'h00000A);
    check_bit("t4_paused", running, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
